morse_key_frontend: RTL

MORSE_KEY_FRONTEND -- requirements
Module: morse_key_frontend

---
 rtl/morse_key_frontend.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/morse_key_frontend.sv
// Morse key front end: synchronizer, debouncer, press/gap classifier and a one-deep symbol buffer.
// Define MORSE_WORD_GAP_EN to enable word-end (code 11) detection; otherwise GAP ends at letter end.
module morse_key_frontend #(
  parameter int DEBOUNCE_CYC   = 1250000,
  parameter int DOT_MIN_CYC    = 6250000,
  parameter int DASH_MIN_CYC   = 37500000,
  parameter int LETTER_GAP_CYC = 37500000,
  parameter int WORD_GAP_CYC   = 87500000,
  parameter int CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_raw,
  output logic       key_db,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  input  logic       sym_ready,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DOT_MIN    = CNT_W'(DOT_MIN_CYC);
  localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(DASH_MIN_CYC);
  localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_GAP_CYC);
  localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] CODE_DOT    = 2'b00;
  localparam logic [1:0] CODE_DASH   = 2'b01;
  localparam logic [1:0] CODE_LETTER = 2'b10;
`ifdef MORSE_WORD_GAP_EN
  localparam logic [1:0] CODE_WORD   = 2'b11;
`endif

  logic             sync1, sync2;
  logic [CNT_W-1:0] db_cnt;

  state_t           state, state_n;
  logic [CNT_W-1:0] press_cnt, press_n;
  logic [CNT_W-1:0] gap_cnt, gap_n, gap_inc;
  logic             letter_open, open_n;
  logic             load;
  logic [1:0]       load_code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      key_db <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (sync2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DEB_LAST) begin
        db_cnt <= '0;
        key_db <= sync2;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      press_cnt   <= '0;
      gap_cnt     <= '0;
      letter_open <= 1'b0;
    end else begin
      state       <= state_n;
      press_cnt   <= press_n;
      gap_cnt     <= gap_n;
      letter_open <= open_n;
    end
  end

  // The gap counter saturates at the word gap so it can never wrap during a long silence.
  always_comb begin
    state_n   = state;
    press_n   = press_cnt;
    gap_n     = gap_cnt;
    open_n    = letter_open;
    load      = 1'b0;
    load_code = CODE_DOT;
    gap_inc   = (gap_cnt == WORD_GAP) ? gap_cnt : gap_cnt + CNT_ONE;
    case (state)
      IDLE: begin
        if (key_db) begin
          state_n = PRESS;
          press_n = CNT_ONE;
        end
      end
      PRESS: begin
        if (key_db) begin
          if (press_cnt != DASH_MIN) press_n = press_cnt + CNT_ONE;
        end else begin
          press_n = '0;
          gap_n   = '0;
          if (press_cnt < DOT_MIN) begin
            state_n = letter_open ? GAP : IDLE;
          end else begin
            load      = 1'b1;
            load_code = (press_cnt < DASH_MIN) ? CODE_DOT : CODE_DASH;
            open_n    = 1'b1;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (key_db) begin
          state_n = PRESS;
          press_n = CNT_ONE;
        end else begin
          gap_n = gap_inc;
          if (gap_inc == LETTER_GAP && letter_open) begin
            load      = 1'b1;
            load_code = CODE_LETTER;
            open_n    = 1'b0;
`ifndef MORSE_WORD_GAP_EN
            state_n   = IDLE;
            gap_n     = '0;
`endif
          end
`ifdef MORSE_WORD_GAP_EN
          if (gap_inc == WORD_GAP) begin
            load      = 1'b1;
            load_code = CODE_WORD;
            state_n   = IDLE;
            gap_n     = '0;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One pending symbol; a load while the previous one is still unaccepted overwrites it and flags overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_valid <= 1'b0;
      sym_code  <= 2'b00;
      overrun   <= 1'b0;
    end else if (load) begin
      if (sym_valid && !sym_ready) overrun <= 1'b1;
      sym_valid <= 1'b1;
      sym_code  <= load_code;
    end else if (sym_valid && sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

endmodule
